// File: rtl/uart_pkg.sv
// Shared UART definitions: state encodings, baud divisor helper and data-width limits.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_START  = 3'b001,
    ST_DATA   = 3'b010,
    ST_PARITY = 3'b011,
    ST_STOP   = 3'b100
  } uart_state_e;

  localparam int DATA_SIZE_MIN = 5;
  localparam int DATA_SIZE_MAX = 10;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake and status bundle of the UART transmitter.
interface uart_tx_if #(
  parameter int DATA_SIZE = 8
);
  logic                 tx_valid;
  logic [DATA_SIZE-1:0] tx_data;
  logic                 tx_ready;
  logic                 tx;
  logic                 busy;
  logic                 done;

  modport master (output tx_valid, tx_data, input tx_ready, tx, busy, done);
  modport slave  (input tx_valid, tx_data, output tx_ready, tx, busy, done);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..DIV-1, restarts to 0 while i_restart is high,
// and flags the last clock of each bit period on o_tick.
module uart_baud_gen #(
  parameter int DIV = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = (r_cnt == LAST) && !i_restart;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_SIZE data bits LSB first, optional parity, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to add the parity bit (even or odd per PARITY_ODD).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 10000,
  parameter int BAUD_RATE  = 2000,
  parameter int DATA_SIZE  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_SIZE - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  generate
    if (DATA_SIZE < DATA_SIZE_MIN || DATA_SIZE > DATA_SIZE_MAX) begin : g_bad_size
      $error("uart_tx: DATA_SIZE out of range");
    end
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_par
      $error("uart_tx: PARITY_ODD must be 0 or 1");
    end
  endgenerate

  uart_state_e          r_state;
  logic [DATA_SIZE-1:0] r_shift;
  logic [3:0]           r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_tick;
  logic                 w_restart;
`ifdef UART_TX_PARITY_EN
  localparam logic PODD_BIT = 1'(PARITY_ODD);
  logic r_parity;
`endif

  // The bit timer is held at zero while idle, so every frame starts on a fresh bit period.
  assign w_restart = (r_state == ST_IDLE);

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk       (clk),
    .reset     (reset),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= 4'd0;
      r_stop_cnt <= 1'b0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.tx_valid && r_ready) begin
            r_shift    <= bus.tx_data;
            r_tx       <= 1'b0;
            r_state    <= ST_START;
            r_busy     <= 1'b1;
            r_ready    <= 1'b0;
            r_bit_cnt  <= 4'd0;
            r_stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= (^bus.tx_data) ^ PODD_BIT;
`endif
          end else begin
            r_tx    <= 1'b1;
            r_ready <= 1'b1;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[DATA_SIZE-1:1]};
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= ST_PARITY;
`else
              r_tx    <= 1'b1;
              r_state <= ST_STOP;
`endif
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= {1'b0, r_shift[DATA_SIZE-1:1]};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick) begin
            if (r_stop_cnt == LAST_STOP) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end else begin
              r_stop_cnt <= r_stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_tx    <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx       = r_tx;
  assign bus.tx_ready = r_ready;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx (DIV=5, 8 data bits, 1 stop bit, even parity when enabled).
module tb_uart_tx;

  localparam int DIV = 5;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          abort_at;
    bit          gap1;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  uart_tx_if #(.DATA_SIZE(8)) bus();

  uart_tx #(
    .CLK_FREQ  (10000),
    .BAUD_RATE (2000),
    .DATA_SIZE (8),
    .STOP_BITS (1),
    .PARITY_ODD(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected line bits, first transmitted bit first: start, data LSB first, parity, stop.
  task automatic push_exp(input string dbits, input string pbit, input int abort_at, input bit gap1);
    exp_t  e;
    string s;
    s = {"0", dbits};
    s = PAR_EN ? {s, pbit} : s;
    s = {s, "1"};
    e.bits     = '0;
    e.nbits    = s.len();
    e.abort_at = abort_at;
    e.gap1     = gap1;
    for (int i = 0; i < s.len(); i++) e.bits[i] = (s.getc(i) == 8'h31);
    exp_q.push_back(e);
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.busy) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    bit   prev_busy = 1'b0;
    bit   chk_low   = 1'b0;
    int   cyc = 0, last_done = -100, tot, act, expb, early;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_low) begin
        chk("done_width", int'(bus.done), 0);
        chk_low = 1'b0;
      end
      if (bus.busy && !prev_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", 1, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.gap1) chk("b2b_gap", cyc - last_done, 1);
          tot   = e.nbits * DIV;
          early = 0;
          act   = 0;
          expb  = 0;
          for (int j = 0; j <= tot; j++) begin
            if (j > 0) begin
              @(negedge clk);
              cyc++;
            end
            if (j == e.abort_at) begin
              chk("abort_tx", int'(bus.tx), 1);
              chk("abort_busy", int'(bus.busy), 0);
              act = 0;
              for (int w = 0; w < 40; w++) begin
                act = act | int'(bus.done);
                @(negedge clk);
                cyc++;
              end
              chk("abort_no_done", act, 0);
              break;
            end
            if (j < tot) begin
              if (j % DIV == 0) begin
                expb = int'(e.bits[j / DIV]);
                act  = expb;
              end
              if (int'(bus.tx) != expb) act = int'(bus.tx);
              if (bus.done || !bus.busy) early = 1;
              if (j % DIV == DIV - 1) chk($sformatf("bit%0d", j / DIV), act, expb);
            end else begin
              chk("frame_busy_done", early, 0);
              chk("done_pulse", int'(bus.done), 1);
              chk("end_tx", int'(bus.tx), 1);
              chk("end_busy", int'(bus.busy), 0);
              chk("end_ready", int'(bus.tx_ready), 1);
              last_done = cyc;
              chk_low   = 1'b1;
            end
          end
        end
        prev_busy = 1'b0;
      end else begin
        prev_busy = bus.busy;
      end
    end
  end

  initial begin : stim
    reset        = 1'b0;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", int'(bus.tx), 1);
    chk("rst_ready", int'(bus.tx_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    bus.tx_valid = 1'b0;
    reset        = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, data changed right after accept
    push_exp("10100101", "0", -1, 1'b0);
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    wait_busy();
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    wait_done();
    repeat (2) @(negedge clk);

    // 0x0F, valid pulsed while busy must not be queued
    push_exp("11110000", "0", -1, 1'b0);
    bus.tx_data  = 8'h0F;
    bus.tx_valid = 1'b1;
    wait_busy();
    bus.tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    bus.tx_data  = 8'h33;
    bus.tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.tx_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("no_queue_busy", int'(bus.busy), 0);

    // back-to-back 0x55 then 0xAA with valid held
    push_exp("10101010", "0", -1, 1'b0);
    push_exp("01010101", "0", -1, 1'b1);
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    wait_busy();
    bus.tx_data  = 8'hAA;
    wait_done();
    @(negedge clk);
    bus.tx_valid = 1'b0;
    wait_done();
    repeat (2) @(negedge clk);

    // 0x3C aborted by reset during data bit 3
    push_exp("00111100", "0", 22, 1'b0);
    bus.tx_data  = 8'h3C;
    bus.tx_valid = 1'b1;
    wait_busy();
    bus.tx_valid = 1'b0;
    repeat (21) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (45) @(negedge clk);

    // 0x07 after abort, odd popcount so even parity bit is 1
    push_exp("11100000", "1", -1, 1'b0);
    bus.tx_data  = 8'h07;
    bus.tx_valid = 1'b1;
    wait_busy();
    bus.tx_valid = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    chk("watchdog", 0, 1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
